// File: rtl/core_pkg.sv
// Shared decode constants and branch-resolve FSM state for the core back end.
package core_pkg;

  // Opcode values found in code[6:0]
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Conditional branch funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside the 12-bit decoder code
  localparam int unsigned CODE_W      = 12;
  localparam int unsigned CODE_OP_LSB = 0;
  localparam int unsigned CODE_OP_MSB = 6;
  localparam int unsigned CODE_F3_LSB = 7;
  localparam int unsigned CODE_F3_MSB = 9;
  localparam int unsigned CODE_F7B5   = 10;
  localparam int unsigned CODE_RSVD   = 11;

  // Branch resolve FSM state
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: decides taken from funct3 and two operands.
module branch_cmp
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1Val,
  input  logic [XLEN-1:0] rs2Val,
  output logic            taken
);

  // Select the comparison; reserved funct3 encodings are never taken
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1Val == rs2Val);
      F3_BNE:  taken = (rs1Val != rs2Val);
      F3_BLT:  taken = ($signed(rs1Val) <  $signed(rs2Val));
      F3_BGE:  taken = ($signed(rs1Val) >= $signed(rs2Val));
      F3_BLTU: taken = (rs1Val <  rs2Val);
      F3_BGEU: taken = (rs1Val >= rs2Val);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches/JAL/JALR, redirects fetch, squashes wrong-path instructions
// and keeps saturating branch statistics.
module branch_resolve
  import core_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc,
  input  logic              isBranch,
  input  logic [CODE_W-1:0] code,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   rs1Val,
  input  logic [XLEN-1:0]   rs2Val,
  output logic [XLEN-1:0]   pcBranch,
  output logic              originPc,
  output logic              squash,
  output logic              linkWrite,
  output logic [XLEN-1:0]   linkValue,
  output logic [CNT_W-1:0]  branchCount,
  output logic [CNT_W-1:0]  takenCount
);

  localparam int unsigned SQ_W = 3;

  br_state_e         state;
  logic [SQ_W-1:0]   sq_cnt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              cmp_taken;
  logic              taken_c;
  logic              link_c;
  logic [XLEN-1:0]   target_c;
  logic              unused_code_bits;

  assign opcode = code[CODE_OP_MSB:CODE_OP_LSB];
  assign funct3 = code[CODE_F3_MSB:CODE_F3_LSB];
  // funct7 bit 5 and the reserved bit play no part in branch resolution
  assign unused_code_bits = code[CODE_F7B5] ^ code[CODE_RSVD];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (funct3),
    .rs1Val (rs1Val),
    .rs2Val (rs2Val),
    .taken  (cmp_taken)
  );

  // Decode the instruction class into taken, link and target
  always_comb begin
    taken_c  = 1'b0;
    link_c   = 1'b0;
    target_c = pc + imm;
    case (opcode)
      OP_BRANCH: taken_c = cmp_taken;
      OP_JAL: begin
        taken_c = 1'b1;
        link_c  = 1'b1;
      end
      OP_JALR: begin
        taken_c  = 1'b1;
        link_c   = 1'b1;
        target_c = (rs1Val + imm) & ~XLEN'(1);
      end
      default: taken_c = 1'b0;
    endcase
  end

  // Wrong-path flag follows the FSM state directly
  assign squash = (state == ST_SQUASH);

  // FSM, redirect/link registers and saturating counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      sq_cnt      <= '0;
      pcBranch    <= '0;
      originPc    <= 1'b0;
      linkWrite   <= 1'b0;
      linkValue   <= '0;
      branchCount <= '0;
      takenCount  <= '0;
    end else begin
      originPc  <= 1'b0;
      linkWrite <= 1'b0;
      case (state)
        ST_RUN: begin
          if (isBranch) begin
            if (branchCount != '1) branchCount <= branchCount + CNT_W'(1);
            if (taken_c) begin
              pcBranch <= target_c;
              originPc <= 1'b1;
              if (takenCount != '1) takenCount <= takenCount + CNT_W'(1);
              sq_cnt   <= SQ_W'(SQUASH_CYCLES);
              state    <= ST_SQUASH;
              if (link_c) begin
                linkWrite <= 1'b1;
                linkValue <= pc + XLEN'(4);
              end
            end
          end
        end
        ST_SQUASH: begin
          if (sq_cnt <= SQ_W'(1)) begin
            sq_cnt <= '0;
            state  <= ST_RUN;
          end else begin
            sq_cnt <= sq_cnt - SQ_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve against a behavioural model.
// Two instances share stimulus: SQUASH_CYCLES=1/CNT_W=16 and SQUASH_CYCLES=3/CNT_W=4.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, imm, rs1Val, rs2Val;
  logic        isBranch;
  logic [11:0] code;

  logic [31:0] pcb1, lv1, pcb3, lv3;
  logic        org1, sq1, lw1, org3, sq3, lw3;
  logic [15:0] bc1, tc1;
  logic [3:0]  bc3, tc3;

  int n_vec = 0;
  int n_err = 0;

  // reference model state, index 0 = dut1, index 1 = dut3
  int unsigned m_sq[2];
  int unsigned m_bc[2];
  int unsigned m_tc[2];
  logic [31:0] m_pcb[2];
  logic [31:0] m_lv[2];
  bit          m_org[2];
  bit          m_lw[2];
  int unsigned m_sqc[2] = '{1, 3};
  int unsigned m_max[2] = '{65535, 15};

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .SQUASH_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .pc(pc), .isBranch(isBranch), .code(code),
    .imm(imm), .rs1Val(rs1Val), .rs2Val(rs2Val), .pcBranch(pcb1),
    .originPc(org1), .squash(sq1), .linkWrite(lw1), .linkValue(lv1),
    .branchCount(bc1), .takenCount(tc1)
  );

  branch_resolve #(.XLEN(32), .SQUASH_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .pc(pc), .isBranch(isBranch), .code(code),
    .imm(imm), .rs1Val(rs1Val), .rs2Val(rs2Val), .pcBranch(pcb3),
    .originPc(org3), .squash(sq3), .linkWrite(lw3), .linkValue(lv3),
    .branchCount(bc3), .takenCount(tc3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ISA-level meaning of the presented instruction
  function automatic void resolve(output bit tk, output bit lk, output logic [31:0] tgt);
    logic [6:0] op;
    logic [2:0] f3;
    op  = code[6:0];
    f3  = code[9:7];
    tk  = 1'b0;
    lk  = 1'b0;
    tgt = pc + imm;
    if (op == 7'h63) begin
      case (f3)
        3'd0: tk = (rs1Val == rs2Val);
        3'd1: tk = (rs1Val != rs2Val);
        3'd4: tk = ($signed(rs1Val) < $signed(rs2Val));
        3'd5: tk = ($signed(rs1Val) >= $signed(rs2Val));
        3'd6: tk = (rs1Val < rs2Val);
        3'd7: tk = (rs1Val >= rs2Val);
        default: tk = 1'b0;
      endcase
    end else if (op == 7'h6F) begin
      tk = 1'b1;
      lk = 1'b1;
    end else if (op == 7'h67) begin
      tk = 1'b1;
      lk = 1'b1;
      tgt = (rs1Val + imm) & 32'hFFFF_FFFE;
    end
  endfunction

  task automatic model_edge();
    bit tk, lk;
    logic [31:0] tgt;
    resolve(tk, lk, tgt);
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_sq[i] = 0; m_bc[i] = 0; m_tc[i] = 0;
        m_pcb[i] = '0; m_lv[i] = '0; m_org[i] = 0; m_lw[i] = 0;
      end else if (m_sq[i] > 0) begin
        m_sq[i]--;
        m_org[i] = 0;
        m_lw[i]  = 0;
      end else begin
        m_org[i] = 0;
        m_lw[i]  = 0;
        if (isBranch) begin
          if (m_bc[i] < m_max[i]) m_bc[i]++;
          if (tk) begin
            m_pcb[i] = tgt;
            m_org[i] = 1;
            if (m_tc[i] < m_max[i]) m_tc[i]++;
            m_sq[i] = m_sqc[i];
            if (lk) begin
              m_lw[i] = 1;
              m_lv[i] = pc + 32'd4;
            end
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] pcb, input logic org,
                          input logic sq, input logic lw, input logic [31:0] lv,
                          input logic [15:0] bc, input logic [15:0] tc);
    chk($sformatf("dut%0d.squash", i), 64'(sq), 64'(m_sq[i] > 0));
    chk($sformatf("dut%0d.originPc", i), 64'(org), 64'(m_org[i]));
    chk($sformatf("dut%0d.pcBranch", i), 64'(pcb), 64'(m_pcb[i]));
    chk($sformatf("dut%0d.linkWrite", i), 64'(lw), 64'(m_lw[i]));
    if (m_lw[i]) chk($sformatf("dut%0d.linkValue", i), 64'(lv), 64'(m_lv[i]));
    chk($sformatf("dut%0d.branchCount", i), 64'(bc), 64'(m_bc[i]));
    chk($sformatf("dut%0d.takenCount", i), 64'(tc), 64'(m_tc[i]));
  endtask

  // drive one instruction, clock it in, then compare both instances
  task automatic apply(input logic r, input logic isb, input logic [11:0] c,
                       input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b);
    reset = r; isBranch = isb; code = c; pc = p; imm = im; rs1Val = a; rs2Val = b;
    @(posedge clk);
    model_edge();
    #1;
    cmp_inst(0, pcb1, org1, sq1, lw1, lv1, bc1, tc1);
    cmp_inst(1, pcb3, org3, sq3, lw3, lv3, 16'(bc3), 16'(tc3));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [11:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {2'b00, f3, op};
  endfunction

  initial begin
    reset = 1'b0; isBranch = 1'b0; code = '0; pc = '0; imm = '0; rs1Val = '0; rs2Val = '0;
    @(posedge clk); #1;
    do_reset();
    do_reset();
    chk("reset.squash", 64'(sq1), 64'd0);
    chk("reset.takenCount", 64'(tc1), 64'd0);

    // BEQ taken
    apply(1'b1, 1'b1, mk(3'd0, 7'h63), 32'h100, 32'h20, 32'd5, 32'd5);
    chk("beq.originPc", 64'(org1), 64'd1);
    chk("beq.pcBranch", 64'(pcb1), 64'h120);
    chk("beq.squash", 64'(sq1), 64'd1);
    chk("beq.takenCount", 64'(tc1), 64'd1);
    idle(1);
    chk("beq.squash_end", 64'(sq1), 64'd0);
    idle(2);

    // BLT signed taken, BLTU same operands not taken
    do_reset();
    apply(1'b1, 1'b1, mk(3'd4, 7'h63), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
    chk("blt.originPc", 64'(org1), 64'd1);
    idle(3);
    apply(1'b1, 1'b1, mk(3'd6, 7'h63), 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
    chk("bltu.originPc", 64'(org1), 64'd0);
    chk("bltu.branchCount", 64'(bc1), 64'd2);

    // JALR target with bit 0 cleared, link write
    apply(1'b1, 1'b1, mk(3'd0, 7'h67), 32'h40, 32'h4, 32'h203, 32'h0);
    chk("jalr.pcBranch", 64'(pcb1), 64'h206);
    chk("jalr.linkWrite", 64'(lw1), 64'd1);
    chk("jalr.linkValue", 64'(lv1), 64'h44);
    idle(3);

    // taken BNE followed by JAL during squash
    do_reset();
    apply(1'b1, 1'b1, mk(3'd1, 7'h63), 32'h300, 32'h40, 32'd1, 32'd2);
    apply(1'b1, 1'b1, mk(3'd0, 7'h6F), 32'h304, 32'h80, 32'd0, 32'd0);
    chk("bnejal.originPc", 64'(org1), 64'd0);
    chk("bnejal.takenCount", 64'(tc1), 64'd1);
    chk("bnejal.branchCount", 64'(bc1), 64'd1);
    idle(3);

    // reset during the 3-cycle squash window
    apply(1'b1, 1'b1, mk(3'd0, 7'h63), 32'h500, 32'h8, 32'd7, 32'd7);
    idle(1);
    chk("rsq.squash_before", 64'(sq3), 64'd1);
    do_reset();
    chk("rsq.squash", 64'(sq3), 64'd0);
    chk("rsq.originPc", 64'(org3), 64'd0);
    chk("rsq.branchCount", 64'(bc3), 64'd0);
    chk("rsq.takenCount", 64'(tc3), 64'd0);
    apply(1'b1, 1'b1, mk(3'd5, 7'h63), 32'h600, 32'hFFFF_FFF0, 32'd3, 32'd3);
    chk("rsq.next_redirect", 64'(org3), 64'd1);
    chk("rsq.next_target", 64'(pcb3), 64'h5F0);
    idle(3);

    // JAL wrap-around, then saturate the 4-bit counters
    do_reset();
    apply(1'b1, 1'b1, mk(3'd0, 7'h6F), 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
    chk("jalwrap.pcBranch", 64'(pcb1), 64'h4);
    chk("jalwrap.linkValue", 64'(lv1), 64'h0);
    idle(3);
    for (int k = 0; k < 18; k++) begin
      apply(1'b1, 1'b1, mk(3'd0, 7'h63), 32'h1000, 32'h4, 32'd9, 32'd9);
      idle(3);
    end
    chk("sat.takenCount", 64'(tc3), 64'hF);
    chk("sat.branchCount", 64'(bc3), 64'hF);
    chk("sat.takenCount16", 64'(tc1), 64'd19);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 4))
        0, 1:    op = 7'h63;
        2:       op = 7'h6F;
        3:       op = 7'h67;
        default: op = 7'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      apply(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            {2'($urandom), 3'($urandom), op}, $urandom, $urandom, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Back-end partner of the fetch stage. Consumes the decoded instruction stream: pcOut, isBranch, code, imm, plus register operands read by the register file.
- Resolves conditional branches, JAL and JALR. Drives the redirect pair (pcBranch, originPc) back into fetch.
- Squashes wrong-path instructions until the redirect has taken effect in fetch.
- Sits between register read and writeback in the single-issue core; also keeps branch statistics counters.

Parameters:
- XLEN, 32, datapath width of operands, imm and PC.
- SQUASH_CYCLES, 1, number of rising edges after a redirect during which incoming instructions are wrong-path; legal range 1..7.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- pc  input  XLEN  address of the instruction being presented (fetch pcOut).
- isBranch  input  1  decoder flag: instruction is a conditional branch, JAL or JALR.
- code  input  12  decoder code: [6:0] opcode, [9:7] funct3, [10] funct7 bit 5, [11] reserved (ignored).
- imm  input  XLEN  sign-extended immediate from the decoder.
- rs1Val  input  XLEN  register-file value for rs1.
- rs2Val  input  XLEN  register-file value for rs2.
- pcBranch  output  XLEN  redirect target to fetch.
- originPc  output  1  redirect request to fetch; a one-cycle pulse.
- squash  output  1  current instruction is wrong-path; writeback and memory stages must drop it.
- linkWrite  output  1  JAL/JALR link write enable for rd.
- linkValue  output  XLEN  pc+4 for the link write.
- branchCount  output  CNT_W  resolved branch/jump instructions.
- takenCount  output  CNT_W  redirects issued.

Behaviour:
- Reset: on a rising edge with reset==0, all outputs and internal state go to 0 and the FSM enters RUN. Reset overrides any pending redirect or squash.
- Combinational resolve, evaluated only when isBranch==1:
  - opcode 1100011 (branch), selected by funct3: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. funct3 010/011 is never taken.
  - opcode 1101111 (JAL): always taken; target = pc+imm.
  - opcode 1100111 (JALR): always taken; target = (rs1Val+imm) with bit 0 cleared.
  - Branch target = pc+imm.
  - All adds are modulo 2^XLEN; wrap-around is silently allowed.
  - isBranch==1 with any other opcode: treated as not-taken, and still counted.
- FSM states are RUN and SQUASH.
- RUN, edge with isBranch==1:
  - branchCount increments.
  - If taken: register pcBranch=target, originPc=1 for exactly one cycle, takenCount increments, load the squash counter with SQUASH_CYCLES, go to SQUASH.
  - JAL/JALR additionally register linkWrite=1 and linkValue=pc+4 for one cycle.
- RUN, edge with isBranch==0: originPc=0, linkWrite=0, state unchanged.
- SQUASH:
  - squash=1 combinationally. Incoming instructions are ignored: no counter update, no redirect, no link, even if isBranch==1.
  - Counter decrements each edge; when it reaches 0, return to RUN with squash=0.
  - originPc is 0 throughout. A second back-to-back pulse never occurs, so fetch's consecutive-redirect filter is never relied on.
- pcBranch holds its last value when originPc==0.
- Counters saturate at all-ones; they do not wrap.
- Latency: redirect is visible one rising edge after the branch is presented, which is before fetch's falling-edge PC update in the same cycle.
- Reset asserted during SQUASH: state goes to RUN and squash deasserts on that same edge.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR;
  - funct3 constants F3_BEQ through F3_BGEU;
  - code-field bit positions;
  - FSM state typedef.
- One natural sub-module, branch_cmp: a combinational comparator taking funct3, rs1Val and rs2Val and returning taken. It is reused later by the ALU.

Test Plan:
- BEQ with pc=0x100, imm=0x20, rs1Val=rs2Val=5 -> next edge: originPc=1, pcBranch=0x120, squash=1 for 1 cycle, takenCount=1.
- BLT with rs1Val=0xFFFFFFFF, rs2Val=1 -> taken. BLTU with the same operands -> not taken, originPc stays 0, branchCount=2.
- JALR with pc=0x40, rs1Val=0x203, imm=0x4 -> pcBranch=0x206, linkWrite=1, linkValue=0x44.
- Taken BNE followed immediately by a taken JAL during SQUASH (SQUASH_CYCLES=1) -> only the first redirect issues; takenCount=1, branchCount=1.
- Reset driven low during SQUASH_CYCLES=3 after one cycle -> next edge: squash=0, originPc=0, both counters=0; the next branch resolves normally.
- JAL with pc=0xFFFFFFFC, imm=8 -> pcBranch=0x4 (wrap). Force takenCount=0xFFFF and issue one more taken branch -> takenCount stays 0xFFFF.
